// File: rtl/obc_slice_accumulator_if.sv
// Bus between the OBC bit-slice accumulator and its controller/ROM side:
// start/x_in request, per-slice ROM lookup (slice, m -> romout), and result/done.
interface obc_slice_accumulator_if #(
   parameter int DW   = 16,
   parameter int ACCW = 48
);
   logic              start;
   logic [16*DW-1:0]  x_in;
   logic              busy;
   logic [15:0]       slice;
   logic              m;
   logic [31:0]       romout;
   logic [ACCW-1:0]   result;
   logic              done;

   modport master (
      output start, x_in, romout,
      input  busy, slice, m, result, done
   );

   modport slave (
      input  start, x_in, romout,
      output busy, slice, m, result, done
   );
endinterface

// File: rtl/obc_slice_accumulator.sv
// Bit-serial OBC accumulator: DW slices of 16 samples, ROM partial sums shifted by k.
// Optional macro OBC_OFFSET_EN adds an offset port; result becomes visible the cycle after done.
module obc_slice_accumulator #(
   parameter int DW   = 16,
   parameter int ACCW = 48
) (
   input logic clk,
   input logic rst,
`ifdef OBC_OFFSET_EN
   input logic signed [ACCW-1:0] offset,
`endif
   obc_slice_accumulator_if.slave bus
);
   localparam int KW = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(DW - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [ACCW-1:0]  acc_q, acc_d;
   logic [ACCW-1:0]  result_q, result_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [DW-1:0]    lane_q [16];
   logic [DW-1:0]    lane_d [16];
   logic [15:0]      slice_raw;
   logic [ACCW-1:0]  rom_ext;
   logic [ACCW-1:0]  addend;
   logic [ACCW-1:0]  const_term;
   logic             capture;
   logic             running;

   assign capture = (state_q == ST_IDLE) && bus.start;
   assign running = (state_q == ST_RUN);

   // Each lane holds one sample; its LSB is that sample's bit for the current slice.
   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_lane
         assign slice_raw[gi] = lane_q[gi][0];
         assign lane_d[gi] = capture ? bus.x_in[gi*DW +: DW] :
                             running ? (lane_q[gi] >> 1) : lane_q[gi];

         always_ff @(posedge clk) begin
            if (rst) begin
               lane_q[gi] <= '0;
            end else begin
               lane_q[gi] <= lane_d[gi];
            end
         end
      end
   endgenerate

   assign rom_ext = ACCW'($signed(bus.romout));
   assign addend  = rom_ext << k_q;

`ifdef OBC_OFFSET_EN
   assign const_term = offset;
`else
   assign const_term = '0;
`endif

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      acc_d    = acc_q;
      result_d = result_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_RUN;
               k_d     = '0;
               acc_d   = '0;
            end
         end
         ST_RUN: begin
            acc_d = acc_q + addend;
            k_d   = k_q + 1'b1;
            if (k_q == K_LAST) begin
               state_d = ST_DONE;
               k_d     = '0;
               done_d  = 1'b1;
            end
         end
         ST_DONE: begin
            result_d = acc_q + const_term;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         k_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.slice  = running ? slice_raw : 16'h0000;
   assign bus.m      = running && (k_q == K_LAST);
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
endmodule

// File: tb/tb_obc_slice_accumulator.sv
// Table-driven bench for obc_slice_accumulator with a scoreboard of expected results
// and a distributed-arithmetic ROM model whose expected value is a plain dot product.
module tb_obc_slice_accumulator;
   localparam int DW   = 16;
   localparam int ACCW = 48;
   localparam int XW   = 16 * DW;
   localparam int ROM_CONST = 0;
   localparam int ROM_DA    = 1;
   localparam int NVEC      = 9;

   typedef struct {
      logic [XW-1:0]   x;
      int              mode;
      logic [31:0]     c;
      logic [ACCW-1:0] exp;
      bit              chk_slice;
      int              restart_at;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   obc_slice_accumulator_if #(.DW(DW), .ACCW(ACCW)) bus ();

`ifdef OBC_OFFSET_EN
   localparam logic [ACCW-1:0] OFF = 48'd100;
   logic signed [ACCW-1:0] offset;
   assign offset = OFF;
   obc_slice_accumulator #(.DW(DW), .ACCW(ACCW)) dut (
      .clk(clk), .rst(rst), .offset(offset), .bus(bus)
   );
`else
   localparam logic [ACCW-1:0] OFF = '0;
   obc_slice_accumulator #(.DW(DW), .ACCW(ACCW)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
`endif

   int                rom_mode;
   logic [31:0]       rom_c;
   logic signed [31:0] rom_sum;
   int                n_vec = 0;
   int                n_miss = 0;
   logic [ACCW-1:0]   exp_q[$];
   vec_t              tbl[NVEC];

   function automatic int coef(input int i);
      return (i % 2 == 1) ? -(i + 3) : (2 * i + 1);
   endfunction

   // ROM model: sum of coefficients of the samples whose bit is set, negated on the MSB slice.
   always_comb begin
      rom_sum = '0;
      for (int i = 0; i < 16; i++)
         if (bus.slice[i]) rom_sum = rom_sum + 32'(coef(i));
   end
   assign bus.romout = (rom_mode == ROM_CONST) ? rom_c : (bus.m ? -rom_sum : rom_sum);

   function automatic logic [ACCW-1:0] dot(input logic [XW-1:0] x);
      longint s = 0;
      for (int i = 0; i < 16; i++)
         s += longint'(coef(i)) * longint'($signed(x[i*DW +: DW]));
      return s[ACCW-1:0];
   endfunction

   function automatic logic [ACCW-1:0] const_exp(input logic [31:0] c);
      longint s = longint'($signed(c)) * longint'((1 << DW) - 1);
      return s[ACCW-1:0];
   endfunction

   function automatic logic [XW-1:0] rand_x();
      logic [XW-1:0] r;
      for (int j = 0; j < XW / 32; j++) r[j*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [XW-1:0] rep(input logic [DW-1:0] s);
      return {16{s}};
   endfunction

   function automatic vec_t mk(input logic [XW-1:0] x, input int mode, input logic [31:0] c,
                               input logic [ACCW-1:0] exp, input bit chk, input int restart);
      vec_t v;
      v.x = x; v.mode = mode; v.c = c; v.exp = exp; v.chk_slice = chk; v.restart_at = restart;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic run_txn(input int idx, input vec_t v);
      int done_n = -1;
      int done_cnt = 0;
      int busy_cnt = 0;
      bit have_e = 1'b0;
      logic [ACCW-1:0] e = '0;
      logic [15:0] es;
      @(negedge clk);
      bus.x_in = v.x; rom_mode = v.mode; rom_c = v.c; bus.start = 1'b1;
      exp_q.push_back(v.exp + OFF);
      for (int n = 1; n <= DW + 2; n++) begin
         @(posedge clk); #1;
         if (n == 1) bus.start = 1'b0;
         if (bus.done) begin
            done_cnt++; done_n = n;
            if (exp_q.size() > 0 && !have_e) begin e = exp_q.pop_front(); have_e = 1'b1; end
         end
         if (n == DW + 2) begin
            check($sformatf("v%0d busy_after", idx), bus.busy, 0);
            if (have_e) check($sformatf("v%0d result", idx), bus.result, e);
         end else if (bus.busy) busy_cnt++;
         if (n == DW - 1 || n == DW) check($sformatf("v%0d m_k%0d", idx, n - 1), bus.m, (n == DW));
         if (v.chk_slice && n <= DW + 1) begin
            es = (n == 1 || n == DW) ? 16'h0001 : 16'h0000;
            check($sformatf("v%0d slice_c%0d", idx, n), bus.slice, es);
         end
         if (v.restart_at > 0 && n == v.restart_at) begin bus.start = 1'b1; bus.x_in = ~v.x; end
         if (v.restart_at > 0 && n == v.restart_at + 1) bus.start = 1'b0;
      end
      check($sformatf("v%0d done_cycle", idx), done_n, DW + 1);
      check($sformatf("v%0d done_count", idx), done_cnt, 1);
      check($sformatf("v%0d busy_cycles", idx), busy_cnt, DW + 1);
      exp_q.delete();
   endtask

   task automatic rst_mid_run();
      logic [XW-1:0] x1, x2;
      int done_n = -1;
      int done_cnt = 0;
      bit have_e = 1'b0;
      logic [ACCW-1:0] e = '0;
      x1 = rand_x(); x2 = rand_x();
      @(negedge clk);
      bus.x_in = x1; rom_mode = ROM_DA; bus.start = 1'b1;
      for (int n = 1; n <= DW + 10; n++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            done_cnt++; done_n = n;
            if (exp_q.size() > 0 && !have_e) begin e = exp_q.pop_front(); have_e = 1'b1; end
         end
         if (n == DW + 9 && have_e) check("rst_mid result", bus.result, e);
         case (n)
            1: bus.start = 1'b0;
            5: rst = 1'b1;
            6: begin
               rst = 1'b0;
               check("rst_mid busy", bus.busy, 0);
               check("rst_mid result_clr", bus.result, 0);
               check("rst_mid slice", bus.slice, 0);
            end
            7: begin
               bus.start = 1'b1; bus.x_in = x2;
               exp_q.push_back(dot(x2) + OFF);
            end
            8: bus.start = 1'b0;
            default: ;
         endcase
      end
      check("rst_mid done_cycle", done_n, DW + 8);
      check("rst_mid done_count", done_cnt, 1);
      exp_q.delete();
   endtask

   initial begin
      logic [XW-1:0] xr;
      bus.start = 1'b0; bus.x_in = '0; rom_mode = ROM_CONST; rom_c = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", bus.busy, 0);
      check("reset done", bus.done, 0);
      check("reset slice", bus.slice, 0);
      check("reset m", bus.m, 0);
      check("reset result", bus.result, 0);
      @(negedge clk);
      rst = 1'b0;

      tbl[0] = mk('0, ROM_CONST, 32'h0, 48'h0, 1'b0, 0);
      tbl[1] = mk(rand_x(), ROM_CONST, 32'h00000001, 48'h00000000FFFF, 1'b0, 0);
      tbl[2] = mk(rand_x(), ROM_CONST, 32'hFFFFFFFF, 48'hFFFFFFFF0001, 1'b0, 0);
      tbl[3] = mk(XW'(16'h8001), ROM_CONST, 32'h0, 48'h0, 1'b1, 0);
      xr = rand_x();
      tbl[4] = mk(xr, ROM_DA, 32'h0, dot(xr), 1'b0, 0);
      tbl[5] = mk(rep(16'h8000), ROM_DA, 32'h0, dot(rep(16'h8000)), 1'b0, 0);
      tbl[6] = mk(rep(16'h7FFF), ROM_DA, 32'h0, dot(rep(16'h7FFF)), 1'b0, 0);
      xr = rand_x();
      tbl[7] = mk(xr, ROM_DA, 32'h0, dot(xr), 1'b0, 8);
      tbl[8] = mk(rand_x(), ROM_CONST, 32'h80000000, const_exp(32'h80000000), 1'b0, 0);

      for (int i = 0; i < NVEC; i++) begin
         run_txn(i, tbl[i]);
         $display("vector %0d applied (mode %0d)", i, tbl[i].mode);
      end
      rst_mid_run();
      $display("reset-mid-run sequence applied");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/obc_slice_accumulator.md
OBC_SLICE_ACCUMULATOR -- requirements
Module: obc_slice_accumulator

Interface
REQ-001 Parameter DW, default 16, meaning sample width in bits, which equals the number of bit-slices per transform.
REQ-002 Parameter ACCW, default 48, meaning accumulator and result width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request to begin one transform; sampled only in IDLE.
REQ-006 x_in  input  16*DW  16 packed samples; sample i occupies bits [i*DW +: DW].
REQ-007 busy  output  1  high in RUN and DONE.
REQ-008 slice  output  16  current bit-slice to the ROM stage; slice[i] is bit k of sample i.
REQ-009 m  output  1  OBC MSB-slice flag to the ROM stage; high only on slice k = DW-1.
REQ-010 romout  input  32  signed partial sum returned combinationally by the ROM stage for the current slice/m.
REQ-011 result  output  ACCW  signed accumulated output; held until the next DONE.
REQ-012 done  output  1  one-cycle pulse when result updates.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 In IDLE with start=1, the FSM SHALL capture x_in into a shift register, set k=0, clear acc, and go to RUN.
REQ-015 In IDLE with start=0, the FSM SHALL stay in IDLE and leave acc and result unchanged.
REQ-016 In RUN, slice SHALL be the LSBs of the 16 shift-register lanes, and m SHALL equal (k == DW-1).
REQ-017 Each RUN cycle SHALL do acc <= acc + (sign_extend(romout, ACCW) << k), shift every lane right by 1, and increment k.
REQ-018 Accumulation SHALL wrap modulo 2^ACCW, with no saturation.
REQ-019 RUN SHALL last exactly DW cycles; the cycle with k = DW-1 SHALL transition to DONE.
REQ-020 In DONE, the block SHALL set result <= acc (plus offset, see REQ-028), pulse done=1 for that cycle, and return to IDLE.
REQ-021 The start pulse on cycle 0 SHALL be followed by DW RUN cycles (1..DW), with done high on cycle DW+1.
REQ-022 A new start SHALL be accepted on cycle DW+2 at the earliest.
REQ-023 start while busy=1 SHALL be ignored, with no queuing and no effect on the ongoing transform.
REQ-024 x_in changes after capture SHALL NOT affect the ongoing transform.
REQ-025 Outside RUN, slice SHALL be 16'h0000 and m SHALL be 0.

Reset
REQ-026 On rst=1 at any clock edge, including mid-RUN or in DONE, the block SHALL:
- return to IDLE
- clear acc, k, the shift register and result to 0
- force done=0, busy=0, slice=0 and m=0
- produce no done pulse for the aborted transform.
REQ-027 rst SHALL take priority over start on the same edge.

Configuration
REQ-028 With macro OBC_OFFSET_EN defined:
- an extra input port offset (ACCW bits, signed) SHALL exist
- DONE SHALL set result <= acc + offset, where offset is the OBC constant term
- offset SHALL be sampled in the DONE cycle.
REQ-029 Without OBC_OFFSET_EN, the offset port SHALL be absent and result SHALL equal acc.

Verification (DW=16, ACCW=48; the bench supplies a romout model)
REQ-030 All samples 0, romout model returns 0, start on cycle 0 -> busy high on cycles 1-17; done only on cycle 17; result=0.
REQ-031 romout held at 32'h00000001 throughout RUN -> result = 48'h00000000FFFF.
REQ-032 romout held at 32'hFFFFFFFF throughout RUN -> result = -65535 = 48'hFFFFFFFF0001.
REQ-033 Sample0=16'h8001, others 0 -> slice=16'h0001 with m=0 on RUN cycle 1; slice=0 on RUN cycles 2-15; slice=16'h0001 with m=1 on RUN cycle 16.
REQ-034 rst on RUN cycle 5, start re-asserted cycle 7 -> no done for first transform; second transform done on cycle 24 with correct result.
REQ-035 Two cases:
- start pulsed on cycles 0 and 8 -> second start ignored, single done on cycle 17.
- with OBC_OFFSET_EN, offset=48'd100 and romout=1 -> result = 65635.
